// File: rtl/lcd_scheduler.sv
// LCD refresh scheduler: arbitrates between the player and host 16x2 displays,
// tracks what each display currently shows, and streams a full two-row frame
// (position command + 16 chars per row) to a single shared LCD writer.
module lcd_scheduler #(
   parameter logic [23:0] REFRESH_MAX = 24'd5000000
) (
   input  logic         clk,
   input  logic         nRst,
   input  logic [127:0] play_row1,
   input  logic [127:0] play_row2,
   input  logic [127:0] host_row1,
   input  logic [127:0] host_row2,
   input  logic         wr_ready,
   output logic         wr_valid,
   output logic         wr_rs,
   output logic [7:0]   wr_data,
   output logic         lcd_sel,
   output logic         busy,
   output logic         frame_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_GRANT, S_CMD1, S_DATA1, S_CMD2, S_DATA2, S_DONE
   } state_t;

   state_t       state_q, state_d;
   logic [23:0]  timer_q, timer_d;
   logic [3:0]   idx_q, idx_d;
   logic         pend_play_q, pend_play_d;
   logic         pend_host_q, pend_host_d;
   logic         last_host_q, last_host_d;
   logic         sel_q, sel_d;
   logic [255:0] shadow_play_q, shadow_play_d;
   logic [255:0] shadow_host_q, shadow_host_d;
   logic [255:0] snap_q, snap_d;

   logic [255:0] live_play, live_host;
   logic         wrap, grant_host, accept;
   logic [7:0]   row1_base, row2_base;

   assign live_play  = {play_row1, play_row2};
   assign live_host  = {host_row1, host_row2};
   assign wrap       = (timer_q == REFRESH_MAX - 24'd1);
   // Host wins when the player is idle, or on a tie when the player went last.
   assign grant_host = !pend_play_q || (pend_host_q && !last_host_q);
   assign accept     = wr_valid && wr_ready;
   // Char i of a row lives at bit offset 8*(15-i); ~idx gives 15-idx.
   assign row1_base  = {1'b1, ~idx_q, 3'b000};
   assign row2_base  = {1'b0, ~idx_q, 3'b000};

   // State and control/tracking registers, all cleared by the async reset.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q       <= S_IDLE;
         timer_q       <= 24'd0;
         idx_q         <= 4'd0;
         pend_play_q   <= 1'b1;
         pend_host_q   <= 1'b1;
         last_host_q   <= 1'b1;
         sel_q         <= 1'b0;
         shadow_play_q <= {32{8'h20}};
         shadow_host_q <= {32{8'h20}};
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         idx_q         <= idx_d;
         pend_play_q   <= pend_play_d;
         pend_host_q   <= pend_host_d;
         last_host_q   <= last_host_d;
         sel_q         <= sel_d;
         shadow_play_q <= shadow_play_d;
         shadow_host_q <= shadow_host_d;
      end
   end

   // Frame snapshot is pure data and is always loaded in GRANT before use.
   always_ff @(posedge clk) begin
      snap_q <= snap_d;
   end

   // Next-state logic: one frame = GRANT, CMD1, 16x DATA1, CMD2, 16x DATA2, DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pend_play_q || pend_host_q) state_d = S_GRANT;
         S_GRANT: state_d = S_CMD1;
         S_CMD1:  if (accept) state_d = S_DATA1;
         S_DATA1: if (accept && idx_q == 4'd15) state_d = S_CMD2;
         S_CMD2:  if (accept) state_d = S_DATA2;
         S_DATA2: if (accept && idx_q == 4'd15) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Timer, char index, pending flags, shadows, snapshot and grant bookkeeping.
   always_comb begin
      timer_d       = wrap ? 24'd0 : timer_q + 24'd1;
      idx_d         = idx_q;
      pend_play_d   = pend_play_q | (live_play != shadow_play_q) | wrap;
      pend_host_d   = pend_host_q | (live_host != shadow_host_q) | wrap;
      last_host_d   = last_host_q;
      sel_d         = sel_q;
      shadow_play_d = shadow_play_q;
      shadow_host_d = shadow_host_q;
      snap_d        = snap_q;
      if (accept && (state_q == S_DATA1 || state_q == S_DATA2)) begin
         idx_d = idx_q + 4'd1;
      end
      if (state_q == S_GRANT) begin
         sel_d = grant_host;
         // The served side's shadow now equals what is being sent; only a
         // timer wrap in this very cycle keeps it pending.
         if (grant_host) begin
            snap_d        = live_host;
            shadow_host_d = live_host;
            pend_host_d   = wrap;
         end else begin
            snap_d        = live_play;
            shadow_play_d = live_play;
            pend_play_d   = wrap;
         end
      end
      if (state_q == S_DONE) begin
         last_host_d = sel_q;
      end
   end

   // Writer-facing outputs decoded from the current state and snapshot.
   always_comb begin
      wr_valid   = 1'b0;
      wr_rs      = 1'b0;
      wr_data    = 8'h00;
      lcd_sel    = (state_q == S_GRANT) ? grant_host : sel_q;
      busy       = (state_q != S_IDLE);
      frame_done = (state_q == S_DONE);
      case (state_q)
         S_CMD1: begin
            wr_valid = 1'b1;
            wr_data  = 8'h80;
         end
         S_DATA1: begin
            wr_valid = 1'b1;
            wr_rs    = 1'b1;
            wr_data  = snap_q[row1_base +: 8];
         end
         S_CMD2: begin
            wr_valid = 1'b1;
            wr_data  = 8'hC0;
         end
         S_DATA2: begin
            wr_valid = 1'b1;
            wr_rs    = 1'b1;
            wr_data  = snap_q[row2_base +: 8];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lcd_scheduler.sv
// Scoreboard bench for lcd_scheduler: a frame-level reference model predicts
// every transfer and the busy/valid/done/select status; a negedge monitor
// pops and compares each accepted transfer.
module tb_lcd_scheduler;

   localparam logic [23:0] RMAX = 24'd100;

   logic         clk = 1'b0;
   logic         nRst;
   logic [127:0] play_row1, play_row2, host_row1, host_row2;
   logic         wr_ready;
   logic         wr_valid, wr_rs, lcd_sel, busy, frame_done;
   logic [7:0]   wr_data;

   always #5 clk = ~clk;

   lcd_scheduler #(.REFRESH_MAX(RMAX)) dut (
      .clk(clk), .nRst(nRst),
      .play_row1(play_row1), .play_row2(play_row2),
      .host_row1(host_row1), .host_row2(host_row2),
      .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_rs(wr_rs),
      .wr_data(wr_data), .lcd_sel(lcd_sel), .busy(busy),
      .frame_done(frame_done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: per side a shadow and a pending bit, plus frame progress.
   logic [255:0] m_shadow [2];
   bit           m_pend   [2];
   int           m_last, m_sel, m_phase, m_k, m_timer;  // phase: 0 idle,1 grant,2 send,3 done
   logic [9:0]   exp_q [$];                             // {sel, rs, data}
   int           rdy_mode = 0;
   int           cyc = 0;

   function automatic logic [127:0] put_char(input logic [127:0] row, input int i,
                                             input logic [7:0] c);
      logic [127:0] r;
      r = row;
      r[127-8*i -: 8] = c;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_shadow[0] = {32{8'h20}};
      m_shadow[1] = {32{8'h20}};
      m_pend[0]   = 1'b1;
      m_pend[1]   = 1'b1;
      m_last      = 1;
      m_sel       = 0;
      m_phase     = 0;
      m_k         = 0;
      m_timer     = 0;
      exp_q.delete();
   endtask

   task automatic model_step();
      logic [255:0] live [2];
      bit           wrap;
      int           w;
      logic         sb;
      live[0] = {play_row1, play_row2};
      live[1] = {host_row1, host_row2};
      wrap    = (m_timer == int'(RMAX) - 1);
      w       = -1;
      case (m_phase)
         0: if (m_pend[0] || m_pend[1]) m_phase = 1;
         1: begin
            if (m_pend[0] && m_pend[1]) w = 1 - m_last;
            else                        w = m_pend[0] ? 0 : 1;
            sb = w[0];
            exp_q.push_back({sb, 1'b0, 8'h80});
            for (int i = 0; i < 16; i++) exp_q.push_back({sb, 1'b1, live[w][255-8*i -: 8]});
            exp_q.push_back({sb, 1'b0, 8'hC0});
            for (int i = 0; i < 16; i++) exp_q.push_back({sb, 1'b1, live[w][127-8*i -: 8]});
            m_sel   = w;
            m_phase = 2;
            m_k     = 0;
         end
         2: if (wr_ready) begin
            m_k++;
            if (m_k == 34) m_phase = 3;
         end
         default: begin
            m_last  = m_sel;
            m_phase = 0;
         end
      endcase
      for (int s = 0; s < 2; s++) begin
         if (s == w) begin
            m_shadow[s] = live[s];
            m_pend[s]   = wrap;
         end else begin
            m_pend[s] = m_pend[s] | (live[s] != m_shadow[s]) | wrap;
         end
      end
      m_timer = wrap ? 0 : m_timer + 1;
   endtask

   task automatic cycle();
      @(posedge clk);
      if (nRst) model_step();
      cyc++;
      #1;
      case (rdy_mode)
         0:       wr_ready = 1'b1;
         1:       wr_ready = 1'($urandom_range(0, 1));
         default: wr_ready = (cyc % 3 == 0);
      endcase
   endtask

   task automatic do_reset(input int n);
      nRst = 1'b0;
      model_reset();
      #1;
      check("rst_wr_valid", 32'(wr_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_wr_rs", 32'(wr_rs), 32'd0);
      check("rst_lcd_sel", 32'(lcd_sel), 32'd0);
      repeat (n) cycle();
      nRst = 1'b1;
   endtask

   // Monitor: status against the model every cycle, transfers against the queue.
   initial begin : mon
      logic       prev_stall;
      logic [9:0] held;
      prev_stall = 1'b0;
      held       = '0;
      forever begin
         @(negedge clk);
         if (!nRst) begin
            prev_stall = 1'b0;
         end else begin
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("wr_valid", 32'(wr_valid), 32'(m_phase == 2));
            check("frame_done", 32'(frame_done), 32'(m_phase == 3));
            if (m_phase != 1) check("lcd_sel", 32'(lcd_sel), 32'(m_sel));
            if (prev_stall && wr_valid)
               check("stall_hold", 32'({lcd_sel, wr_rs, wr_data}), 32'(held));
            if (wr_valid && wr_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL xfer: got %0h expected none", {lcd_sel, wr_rs, wr_data});
               end else begin
                  check("xfer", 32'({lcd_sel, wr_rs, wr_data}), 32'(exp_q.pop_front()));
               end
            end
            prev_stall = wr_valid && !wr_ready;
            held       = {lcd_sel, wr_rs, wr_data};
         end
      end
   end

   initial begin : stim
      bit reached;
      nRst      = 1'b1;
      wr_ready  = 1'b1;
      play_row1 = {16{8'h41}};
      play_row2 = {16{8'h41}};
      host_row1 = {16{8'h41}};
      host_row2 = {16{8'h41}};
      #2;
      do_reset(3);
      // Power-up paint of both sides, player first.
      repeat (90) cycle();
      // Single host char change.
      host_row2 = put_char(host_row2, 3, 8'h5A);
      repeat (80) cycle();
      // Both sides change together.
      play_row1 = put_char(play_row1, 0, 8'h31);
      host_row1 = put_char(host_row1, 15, 8'h32);
      repeat (120) cycle();
      // Writer stalling two cycles out of three.
      rdy_mode  = 2;
      play_row2 = {16{8'h42}};
      repeat (250) cycle();
      // Live row change while the player frame is in its second row.
      rdy_mode = 0;
      reached  = 1'b0;
      for (int t = 0; t < 400 && !reached; t++) begin
         cycle();
         reached = (m_phase == 2 && m_sel == 0 && m_k >= 20);
      end
      check("reach_player_data2", 32'(reached), 32'd1);
      play_row1 = {16{8'h43}};
      repeat (150) cycle();
      // Reset pulse in the middle of a first-row burst.
      reached = 1'b0;
      for (int t = 0; t < 400 && !reached; t++) begin
         cycle();
         reached = (m_phase == 2 && m_k >= 3 && m_k <= 10);
      end
      check("reach_data1", 32'(reached), 32'd1);
      do_reset(3);
      repeat (150) cycle();
      // Random stalls, row edits and occasional resets.
      rdy_mode = 1;
      repeat (3000) begin
         cycle();
         if ($urandom_range(0, 24) == 0) begin
            case ($urandom_range(0, 3))
               0: play_row1 = put_char(play_row1, int'($urandom_range(0, 15)), 8'($urandom_range(32, 126)));
               1: play_row2 = put_char(play_row2, int'($urandom_range(0, 15)), 8'($urandom_range(32, 126)));
               2: host_row1 = put_char(host_row1, int'($urandom_range(0, 15)), 8'($urandom_range(32, 126)));
               default: host_row2 = put_char(host_row2, int'($urandom_range(0, 15)), 8'($urandom_range(32, 126)));
            endcase
         end
         if ($urandom_range(0, 499) == 0) do_reset(2);
      end
      rdy_mode = 0;
      repeat (100) cycle();
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_scheduler.md
LCD_SCHEDULER -- requirements
Module: lcd_scheduler

Interface
REQ-001 Parameter: REFRESH_MAX, default 24'd5000000, clock cycles between forced full repaints of both displays.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: nRst  input  1  reset, asynchronous and active-low.
REQ-004 Port: play_row1, play_row2  input  128 each  player display rows, 16 ASCII chars, char 0 in [127:120].
REQ-005 Port: host_row1, host_row2  input  128 each  host display rows, same packing.
REQ-006 Port: wr_ready  input  1  shared LCD writer accepts the current transfer this cycle.
REQ-007 Port: wr_valid  output  1  transfer offered to the writer.
REQ-008 Port: wr_rs  output  1  0 = command byte, 1 = character byte.
REQ-009 Port: wr_data  output  8  command or character byte.
REQ-010 Port: lcd_sel  output  1  target display: 0 = player, 1 = host.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.
REQ-012 Port: frame_done  output  1  one-cycle pulse after the last byte of a frame is accepted.

Function
REQ-013 Per side, keep a 256-bit shadow of the rows last sent and a pending flag; pending sets when live rows differ from shadow, or when refresh timer wraps.
REQ-014 Refresh timer: counts 0..REFRESH_MAX-1, then wraps to 0; on wrap, both pending flags set; the timer free-runs during frames.
REQ-015 States: IDLE, GRANT, CMD1, DATA1, CMD2, DATA2, DONE.
REQ-016 IDLE -> GRANT when any pending flag is set; otherwise stay.
REQ-017 Arbitration in GRANT: single pending side wins; both pending -> side not granted last wins (round robin); last-grant resets to host, so player wins the first tie.
REQ-018 GRANT (one cycle): latch the winner's 256 live bits into a snapshot, copy the snapshot into that side's shadow, clear its pending flag, drive lcd_sel, go to CMD1.
REQ-019 CMD1: wr_rs=0, wr_data=8'h80; DATA1: wr_rs=1, chars 0..15 of snapshot row1; CMD2: wr_rs=0, wr_data=8'hC0; DATA2: chars 0..15 of row2; total 34 transfers per frame.
REQ-020 Handshake: wr_valid high in CMD1/DATA1/CMD2/DATA2; a transfer completes on a clock edge where wr_valid and wr_ready are both high; wr_data, wr_rs and lcd_sel stay stable until completion.
REQ-021 A 4-bit char index advances only on completion; at index 15 completion, DATA1 -> CMD2 and DATA2 -> DONE, index returns to 0.
REQ-022 Back-to-back: with wr_ready held high, one transfer per cycle, no idle cycles inside a frame; a frame takes 36 cycles from GRANT entry to DONE exit.
REQ-023 DONE (one cycle): frame_done=1, toggle last-grant to the served side, return to IDLE.
REQ-024 Live rows changing mid-frame do not alter bytes sent; the difference against the updated shadow re-raises pending, and a repaint follows.
REQ-025 A pending flag set by the timer for the side currently in service persists and is served after the current frame.
REQ-026 lcd_sel holds its last value in IDLE.
REQ-027 wr_ready while wr_valid=0 is ignored.

Reset
REQ-028 On nRst low, immediately: state IDLE, wr_valid=0, wr_rs=0, wr_data=8'h00, lcd_sel=0, busy=0, frame_done=0, index=0, timer=0, last-grant=host.
REQ-029 Reset sets shadows to all 8'h20 (spaces) and both pending flags to 1, so both displays are painted after reset, player first.
REQ-030 Reset asserted mid-frame aborts the frame without completing it; after release the frame restarts from CMD1 of a new GRANT.

Verification
REQ-031 Release reset, wr_ready=1, all rows "A"x16 -> player frame 80,41x16,C0,41x16 with lcd_sel=0, frame_done, then host frame with lcd_sel=1, then IDLE.
REQ-032 In IDLE, change host_row2 char 3 to 8'h5A -> exactly one host frame; byte 3 of DATA2 is 5A; player not repainted.
REQ-033 Both sides changed in the same cycle after a host frame -> player served first, then host.
REQ-034 wr_ready toggled every 3rd cycle -> wr_data/wr_rs/lcd_sel stable while stalled; still exactly 34 accepted bytes, in order.
REQ-035 Change play_row1 during player DATA2 -> current frame sends old bytes; a second player frame sends new ones.
REQ-036 REFRESH_MAX=100, no row changes -> a frame for both sides every 100 cycles; reset pulse mid-DATA1 -> wr_valid drops at once, both sides repainted after release.
